// File: rtl/systolic_mac_pe.sv
// -----------------------------------------------------------------------------
// systolic_mac_pe
//
// Output-stationary processing element for the systolic MAC fabric. Operands
// are forwarded east (a) and south (b) through one register stage. The signed
// products are accumulated locally, with optional saturation. Finished results
// leave through a per-column partial-sum drain chain that runs north to south.
//
// Parameters
//   DATA_W  operand width, signed two's complement
//   ACC_W   accumulator / partial-sum width (must be >= 2*DATA_W)
//   SAT     1 = clamp on accumulator overflow, 0 = wrap modulo 2^ACC_W
//
// Ports
//   clk             system clock, rising edge
//   reset           asynchronous, active-low reset
//   enable          global advance; 0 holds every register
//   clear           start a new tile (accumulator restarts from zero)
//   a_in / b_in     operands from west / north
//   valid_in        a_in/b_in pair is valid
//   a_out / b_out   registered operands to east / south
//   valid_out       registered valid_in
//   drain           capture the accumulator into the drain chain
//   psum_in         drain chain from the north neighbour
//   psum_valid_in   psum_in is valid
//   psum_out        drain chain to the south neighbour
//   psum_valid_out  psum_out is valid
//   ovf             sticky overflow flag for the current accumulation
// -----------------------------------------------------------------------------
module systolic_mac_pe #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 24,
   parameter bit SAT    = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              clear,
   input  logic [DATA_W-1:0] a_in,
   input  logic [DATA_W-1:0] b_in,
   input  logic              valid_in,
   output logic [DATA_W-1:0] a_out,
   output logic [DATA_W-1:0] b_out,
   output logic              valid_out,
   input  logic              drain,
   input  logic [ACC_W-1:0]  psum_in,
   input  logic              psum_valid_in,
   output logic [ACC_W-1:0]  psum_out,
   output logic              psum_valid_out,
   output logic              ovf
);

   localparam int PROD_W = 2 * DATA_W;

   // Largest positive and most negative accumulator values, used for clamping.
   localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   logic [ACC_W-1:0]         acc;
   logic signed [PROD_W-1:0] prod;
   logic [ACC_W:0]           prod_x;
   logic [ACC_W:0]           base_x;
   logic [ACC_W:0]           sum;
   logic [ACC_W-1:0]         base;
   logic [ACC_W-1:0]         acc_nxt;
   logic                     restart;
   logic                     sum_ovf;
   logic                     ovf_nxt;

   // Both operands are widened to the full product width before multiplying,
   // so the product is the exact signed result.
   assign prod   = PROD_W'($signed(a_in)) * PROD_W'($signed(b_in));
   assign prod_x = {{(ACC_W + 1 - PROD_W){prod[PROD_W-1]}}, prod};

   // NOTE: every signal driven here gets a value before any branch; a path
   // that leaves one unassigned would turn it into a latch.
   always_comb begin
      restart = clear | drain;
      base    = restart ? '0 : acc;
      base_x  = {base[ACC_W-1], base};
      // One guard bit: the sum cannot overflow ACC_W+1 bits, so a mismatch
      // between the two top bits means it does not fit in ACC_W bits.
      sum     = base_x + prod_x;
      sum_ovf = valid_in & (sum[ACC_W] ^ sum[ACC_W-1]);

      acc_nxt = base;
      if (valid_in) begin
         acc_nxt = sum[ACC_W-1:0];
         if (sum_ovf && SAT) begin
            // The guard bit holds the sign of the true sum.
            acc_nxt = sum[ACC_W] ? ACC_MIN : ACC_MAX;
         end
      end

      // A new overflow takes priority over the clear that a tile restart
      // applies to the sticky flag.
      ovf_nxt = sum_ovf | (ovf & ~restart);
   end

   // NOTE: the reset branch clears every register, including the accumulator.
   // A tile must start from zero after reset, so there is no uninitialised
   // state to leave alone.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_out          <= '0;
         b_out          <= '0;
         valid_out      <= 1'b0;
         acc            <= '0;
         ovf            <= 1'b0;
         psum_out       <= '0;
         psum_valid_out <= 1'b0;
      end else if (enable) begin
         // NOTE: non-blocking assignments, so every register samples the
         // pre-edge values; the drain below sees the old acc, not acc_nxt.
         a_out     <= a_in;
         b_out     <= b_in;
         valid_out <= valid_in;
         acc       <= acc_nxt;
         ovf       <= ovf_nxt;
         if (drain) begin
            psum_out       <= acc;
            psum_valid_out <= 1'b1;
         end else begin
            psum_out       <= psum_in;
            psum_valid_out <= psum_valid_in;
         end
      end
   end

endmodule

// File: tb/tb_systolic_mac_pe.sv
// -----------------------------------------------------------------------------
// tb_systolic_mac_pe
//
// Bench for systolic_mac_pe. It uses a 24-bit saturating instance for the
// table-driven vectors. Two 16-bit instances, one saturating and one wrapping,
// receive the same stimulus and cover the overflow behaviour. Inputs are
// driven on the falling edge, and outputs are sampled on the falling edge that
// follows each rising edge.
// -----------------------------------------------------------------------------
module tb_systolic_mac_pe;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        clear;
   logic [7:0]  a_in;
   logic [7:0]  b_in;
   logic        valid_in;
   logic        drain;
   logic [23:0] psum_in;
   logic        psum_valid_in;

   logic [7:0]  a_out, b_out;
   logic        valid_out;
   logic [23:0] psum_out;
   logic        psum_valid_out;
   logic        ovf;

   logic [7:0]  s1_a_out, s1_b_out, s0_a_out, s0_b_out;
   logic        s1_valid_out, s0_valid_out;
   logic [15:0] s1_psum_out, s0_psum_out;
   logic        s1_psum_valid_out, s0_psum_valid_out;
   logic        s1_ovf, s0_ovf;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   systolic_mac_pe #(.DATA_W(8), .ACC_W(24), .SAT(1'b1)) dut (
      .clk(clk), .reset(reset), .enable(enable), .clear(clear),
      .a_in(a_in), .b_in(b_in), .valid_in(valid_in),
      .a_out(a_out), .b_out(b_out), .valid_out(valid_out),
      .drain(drain), .psum_in(psum_in), .psum_valid_in(psum_valid_in),
      .psum_out(psum_out), .psum_valid_out(psum_valid_out), .ovf(ovf)
   );

   systolic_mac_pe #(.DATA_W(8), .ACC_W(16), .SAT(1'b1)) dut_s1 (
      .clk(clk), .reset(reset), .enable(enable), .clear(clear),
      .a_in(a_in), .b_in(b_in), .valid_in(valid_in),
      .a_out(s1_a_out), .b_out(s1_b_out), .valid_out(s1_valid_out),
      .drain(drain), .psum_in(psum_in[15:0]), .psum_valid_in(psum_valid_in),
      .psum_out(s1_psum_out), .psum_valid_out(s1_psum_valid_out), .ovf(s1_ovf)
   );

   systolic_mac_pe #(.DATA_W(8), .ACC_W(16), .SAT(1'b0)) dut_s0 (
      .clk(clk), .reset(reset), .enable(enable), .clear(clear),
      .a_in(a_in), .b_in(b_in), .valid_in(valid_in),
      .a_out(s0_a_out), .b_out(s0_b_out), .valid_out(s0_valid_out),
      .drain(drain), .psum_in(psum_in[15:0]), .psum_valid_in(psum_valid_in),
      .psum_out(s0_psum_out), .psum_valid_out(s0_psum_valid_out), .ovf(s0_ovf)
   );

   typedef struct {
      string       name;
      logic        en, clr, drn, vld;
      logic [7:0]  a, b;
      logic [23:0] pin;
      logic        pv;
      logic [7:0]  ea, eb;
      logic        evo;
      logic [23:0] epsum;
      logic        epvo;
      logic        eovf;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic en, input logic clr, input logic drn, input logic vld,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [23:0] pin, input logic pv);
      enable        = en;
      clear         = clr;
      drain         = drn;
      valid_in      = vld;
      a_in          = a;
      b_in          = b;
      psum_in       = pin;
      psum_valid_in = pv;
   endtask

   task automatic rand_inputs();
      clear         = 1'($urandom);
      drain         = 1'($urandom);
      valid_in      = 1'($urandom);
      a_in          = 8'($urandom);
      b_in          = 8'($urandom);
      psum_in       = 24'($urandom);
      psum_valid_in = 1'($urandom);
   endtask

   // One rising edge, then back to the falling edge for sampling and driving.
   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_main(input string tag, input logic [7:0] ea, input logic [7:0] eb,
                             input logic evo, input logic [23:0] epsum,
                             input logic epvo, input logic eovf);
      check({tag, ".a_out"},          32'(a_out),          32'(ea));
      check({tag, ".b_out"},          32'(b_out),          32'(eb));
      check({tag, ".valid_out"},      32'(valid_out),      32'(evo));
      check({tag, ".psum_out"},       32'(psum_out),       32'(epsum));
      check({tag, ".psum_valid_out"}, 32'(psum_valid_out), 32'(epvo));
      check({tag, ".ovf"},            32'(ovf),            32'(eovf));
   endtask

   task automatic check_sat(input string tag, input logic [15:0] ep1, input logic [15:0] ep0,
                            input logic epv, input logic eo1, input logic eo0);
      check({tag, ".s1_psum_out"},       32'(s1_psum_out),       32'(ep1));
      check({tag, ".s0_psum_out"},       32'(s0_psum_out),       32'(ep0));
      check({tag, ".s1_psum_valid_out"}, 32'(s1_psum_valid_out), 32'(epv));
      check({tag, ".s1_ovf"},            32'(s1_ovf),            32'(eo1));
      check({tag, ".s0_ovf"},            32'(s0_ovf),            32'(eo0));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //           name          en clr drn vld  a      b      pin        pv   ea     eb     evo epsum      epvo eovf
      vecs.push_back('{"mac_3dx2a",  1, 0, 0, 1, 8'h3d, 8'h2a, 24'h0,      0, 8'h3d, 8'h2a, 1, 24'h0,      0, 0});
      vecs.push_back('{"drain_a02",  1, 0, 1, 0, 8'h00, 8'h00, 24'h0,      0, 8'h00, 8'h00, 0, 24'h000a02, 1, 0});
      vecs.push_back('{"mac_neg",    1, 0, 0, 1, 8'hfd, 8'h05, 24'h0,      0, 8'hfd, 8'h05, 1, 24'h0,      0, 0});
      vecs.push_back('{"drain_neg",  1, 0, 1, 0, 8'h00, 8'h00, 24'h0,      0, 8'h00, 8'h00, 0, 24'hfffff1, 1, 0});
      vecs.push_back('{"mac_again",  1, 0, 0, 1, 8'h3d, 8'h2a, 24'h0,      0, 8'h3d, 8'h2a, 1, 24'h0,      0, 0});
      vecs.push_back('{"drain_b2b",  1, 0, 1, 1, 8'h02, 8'h03, 24'h0,      0, 8'h02, 8'h03, 1, 24'h000a02, 1, 0});
      vecs.push_back('{"chain_pass", 1, 0, 0, 0, 8'h00, 8'h00, 24'h123456, 1, 8'h00, 8'h00, 0, 24'h123456, 1, 0});
      vecs.push_back('{"drain_6",    1, 0, 1, 0, 8'h00, 8'h00, 24'h0,      0, 8'h00, 8'h00, 0, 24'h000006, 1, 0});
      vecs.push_back('{"fwd_novld",  1, 0, 0, 0, 8'h7f, 8'h7f, 24'h0,      0, 8'h7f, 8'h7f, 0, 24'h0,      0, 0});
      vecs.push_back('{"clear_mac",  1, 1, 0, 1, 8'h02, 8'h02, 24'h0,      0, 8'h02, 8'h02, 1, 24'h0,      0, 0});
      vecs.push_back('{"clr_drain",  1, 1, 1, 1, 8'h01, 8'h05, 24'h0,      0, 8'h01, 8'h05, 1, 24'h000004, 1, 0});
      vecs.push_back('{"drain_5",    1, 0, 1, 0, 8'h00, 8'h00, 24'h0,      0, 8'h00, 8'h00, 0, 24'h000005, 1, 0});
      vecs.push_back('{"mac_m128sq", 1, 0, 0, 1, 8'h80, 8'h80, 24'h0,      0, 8'h80, 8'h80, 1, 24'h0,      0, 0});
      vecs.push_back('{"mac_m128x",  1, 0, 0, 1, 8'h80, 8'h7f, 24'h0,      0, 8'h80, 8'h7f, 1, 24'h0,      0, 0});
      vecs.push_back('{"drain_80",   1, 0, 1, 0, 8'h00, 8'h00, 24'h0,      0, 8'h00, 8'h00, 0, 24'h000080, 1, 0});
      vecs.push_back('{"stall_1",    0, 1, 1, 1, 8'h11, 8'h22, 24'habcdef, 1, 8'h00, 8'h00, 0, 24'h000080, 1, 0});
      vecs.push_back('{"drain_held", 1, 0, 1, 0, 8'h00, 8'h00, 24'h0,      0, 8'h00, 8'h00, 0, 24'h0,      1, 0});

      // Reset held with random inputs: every output stays zero.
      reset  = 1'b0;
      enable = 1'b1;
      rand_inputs();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         rand_inputs();
      end
      check_main("reset_hold", 8'h00, 8'h00, 1'b0, 24'h0, 1'b0, 1'b0);
      check("reset_hold.s1_ovf", 32'(s1_ovf), 32'h0);

      drive(1, 0, 0, 0, 8'h00, 8'h00, 24'h0, 0);
      reset = 1'b1;

      // Table-driven vectors against the 24-bit instance.
      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].en, vecs[i].clr, vecs[i].drn, vecs[i].vld,
               vecs[i].a, vecs[i].b, vecs[i].pin, vecs[i].pv);
         cyc();
         check_main(vecs[i].name, vecs[i].ea, vecs[i].eb, vecs[i].evo,
                    vecs[i].epsum, vecs[i].epvo, vecs[i].eovf);
      end

      // Saturation and wrap on the 16-bit instances (127*127 = 0x3f01).
      drive(1, 1, 0, 0, 8'h00, 8'h00, 24'h0, 0);
      cyc();
      check_sat("sat_clear", 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
      drive(1, 0, 0, 1, 8'h7f, 8'h7f, 24'h0, 0);
      cyc();
      cyc();
      check_sat("sat_pos2", 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);  // 0x7e02 still fits
      cyc();
      check_sat("sat_pos3", 16'h0, 16'h0, 1'b0, 1'b1, 1'b1);
      cyc();  // s1 saturates again; s0 wraps back in range but ovf stays sticky
      check_sat("sat_pos4", 16'h0, 16'h0, 1'b0, 1'b1, 1'b1);
      drive(1, 0, 1, 0, 8'h00, 8'h00, 24'h0, 0);
      cyc();
      check_sat("sat_drain_pos", 16'h7fff, 16'hfc04, 1'b1, 1'b0, 1'b0);

      // Negative direction: -128*127 = -16256 per cycle.
      drive(1, 0, 0, 1, 8'h80, 8'h7f, 24'h0, 0);
      cyc();
      cyc();
      check_sat("sat_neg2", 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);  // -32512 still fits
      cyc();
      check_sat("sat_neg3", 16'h0, 16'h0, 1'b0, 1'b1, 1'b1);
      drive(1, 0, 1, 0, 8'h00, 8'h00, 24'h0, 0);
      cyc();
      check_sat("sat_drain_neg", 16'h8000, 16'h4180, 1'b1, 1'b0, 1'b0);

      // Three positive products, then clear: ovf drops and acc restarts at zero.
      drive(1, 0, 0, 1, 8'h7f, 8'h7f, 24'h0, 0);
      cyc();
      cyc();
      cyc();
      check_sat("sat_pos3b", 16'h0, 16'h0, 1'b0, 1'b1, 1'b1);
      drive(1, 1, 0, 0, 8'h00, 8'h00, 24'h0, 0);
      cyc();
      check_sat("ovf_clear", 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
      drive(1, 0, 1, 0, 8'h00, 8'h00, 24'h0, 0);
      cyc();
      check_sat("drain_after_clr", 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);

      // Asynchronous reset in the middle of an accumulation.
      drive(1, 0, 0, 1, 8'h7f, 8'h7f, 24'h0, 0);
      cyc();
      cyc();
      drive(1, 0, 0, 1, 8'h7f, 8'h7f, 24'h000055, 1);
      cyc();
      check("pre_reset.s1_ovf", 32'(s1_ovf), 32'h1);
      check("pre_reset.psum_out", 32'(psum_out), 32'h55);
      #2 reset = 1'b0;
      #1;
      check_main("async_reset", 8'h00, 8'h00, 1'b0, 24'h0, 1'b0, 1'b0);
      check("async_reset.s1_ovf", 32'(s1_ovf), 32'h0);
      @(negedge clk);
      reset = 1'b1;
      drive(1, 0, 1, 0, 8'h00, 8'h00, 24'h0, 0);
      cyc();
      check_main("drain_post_rst", 8'h00, 8'h00, 1'b0, 24'h0, 1'b1, 1'b0);
      check("drain_post_rst.s1_psum", 32'(s1_psum_out), 32'h0);

      // Five-cycle stall while the inputs change every 1 ns.
      drive(1, 1, 0, 0, 8'h00, 8'h00, 24'h0, 0);
      cyc();
      drive(1, 0, 0, 1, 8'h12, 8'h34, 24'h000077, 1);  // acc = 18*52 = 0x3a8
      cyc();
      check_main("pre_stall", 8'h12, 8'h34, 1'b1, 24'h000077, 1'b1, 1'b0);
      enable = 1'b0;
      for (int c = 0; c < 5; c++) begin
         for (int t = 0; t < 10; t++) begin
            rand_inputs();
            #1;
         end
         check_main($sformatf("stall_%0d", c), 8'h12, 8'h34, 1'b1, 24'h000077, 1'b1, 1'b0);
      end
      drive(1, 0, 1, 0, 8'h5a, 8'ha5, 24'h0, 0);
      cyc();
      check_main("post_stall", 8'h5a, 8'ha5, 1'b0, 24'h0003a8, 1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
